ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, SHALL set the max cycles the block waits on each RAM handshake phase before aborting.
REQ-002 Port clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 Ports m0_req/m1_req  in  1  SHALL be the request strobes; m0 is instruction fetch, m1 is data.
REQ-005 Ports m0_we/m1_we  in  1  SHALL select the operation: 1 = write, 0 = read.
REQ-006 Ports m0_addr/m1_addr  in  32  SHALL be the word addresses.
REQ-007 Ports m0_wdata/m1_wdata  in  32  SHALL be the write data.
REQ-008 Ports m0_ack/m1_ack  out  1  SHALL be the single-cycle completion pulses.
REQ-009 Ports m0_rdata/m1_rdata  out  32  SHALL be the read data, valid with ack.
REQ-010 Ports m0_err/m1_err  out  1  SHALL be the error flags, valid with ack.
REQ-011 Ports ram_r_addr/ram_w_addr/ram_w_line  out  32  SHALL be the read address, write address and write data to the RAM.
REQ-012 Ports ram_read/ram_write  out  1  SHALL be the RAM operation strobes.
REQ-013 Ports ram_rrdy/ram_wrdy  in  1  SHALL be the RAM ready flags: drop low = busy, return high = done.
REQ-014 Port ram_r_line  in  32  SHALL be the RAM read data.
REQ-015 Port ram_exc  in  1  SHALL be the RAM exception flag.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP.
REQ-017 IDLE: if any req is high, grant one, latch its we/addr/wdata, and go to ISSUE; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin:
  - a lone requester wins;
  - on simultaneous requests, the requester not granted last wins;
  - after reset the pointer favours m0.
REQ-019 ISSUE: drive the latched address on ram_r_addr (read) or ram_w_addr + ram_w_line (write), assert exactly one of ram_read/ram_write, then go to WAIT_LOW.
REQ-020 WAIT_LOW: hold the strobe until the selected rdy (ram_rrdy for read, ram_wrdy for write) is sampled low, then go to WAIT_HIGH.
REQ-021 WAIT_HIGH: hold the strobe until the selected rdy is sampled high, then capture ram_r_line and ram_exc in that same cycle and go to RESP.
REQ-022 RESP: for one cycle,
  - deassert the strobe;
  - pulse the granted requester's ack with rdata = captured line and err = captured exc;
  - return to IDLE.
REQ-023 A write SHALL return rdata = 0 and err = ram_exc.
REQ-024 Minimum latency is 5 cycles from the cycle req is sampled to the cycle ack is high, when the RAM drops rdy after 1 cycle and restores it after 1 cycle.
REQ-025 A per-phase wait counter SHALL reset on entry to WAIT_LOW and to WAIT_HIGH. On reaching TIMEOUT: deassert the strobe, go to RESP, set err = 1, rdata = 0.
REQ-026 Only one request is outstanding at a time. Requests arriving during a transaction stay pending until IDLE.
REQ-027 The latched request SHALL complete even if its req drops before ack.
REQ-028 A req still high in the cycle after ack SHALL count as a new request.
REQ-029 Outside RESP, both acks SHALL be 0. rdata/err SHALL hold their last value until the next ack to that requester.
REQ-030 ram_read and ram_write SHALL never be high in the same cycle.

Reset
REQ-031 When rst_n is low at a clock edge, the following SHALL hold from the next cycle:
  - state = IDLE;
  - ram_read = ram_write = 0;
  - all RAM address/data outputs = 0;
  - acks = 0, rdata = 0, err = 0;
  - round-robin pointer favours m0;
  - wait counter = 0.
REQ-032 A reset during ISSUE/WAIT_LOW/WAIT_HIGH/RESP SHALL abort the transaction with no ack issued.

Verification
REQ-033 Single read: m0 reads 0x10 with RAM data 0x20, rdy low 1 cycle then high -> ram_read high 3 cycles, m0_ack 1 cycle, m0_rdata = 0x20, m0_err = 0, latency 5 cycles.
REQ-034 Simultaneous requests after reset: m0 read 0x4 and m1 write 0x8 = 0xAB -> m0 served first, then m1 (ram_w_addr = 0x8, ram_w_line = 0xAB), with no strobe overlap.
REQ-035 Fairness: m0 and m1 both held high for 4 transactions -> grant order m0, m1, m0, m1.
REQ-036 Timeout: TIMEOUT = 8 and ram_rrdy held high -> strobe drops after 8 WAIT_LOW cycles, ack pulses with err = 1, rdata = 0.
REQ-037 Exception: ram_exc = 1 when rdy rises on an m1 read -> m1_err = 1, m1_rdata = the ram_r_line value.
REQ-038 Reset mid-op: rst_n low during WAIT_HIGH -> strobes 0 the next cycle, no ack; a fresh m1 request then completes normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master (instruction fetch m0, data m1) round-robin arbiter in front of a single RAM port.
// Each grant runs one ready-handshake with the RAM and then returns a single-cycle ack to the winner.
module ram_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] ram_r_addr,
    output logic [31:0] ram_w_addr,
    output logic [31:0] ram_w_line,
    output logic        ram_read,
    output logic        ram_write,
    input  logic        ram_rrdy,
    input  logic        ram_wrdy,
    input  logic [31:0] ram_r_line,
    input  logic        ram_exc
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;       // 0 = m0 owns the transaction, 1 = m1
    logic              rr_m1_q, rr_m1_d;   // 1 = m1 wins the next tie
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ram_r_addr_q, ram_r_addr_d;
    logic [31:0]       ram_w_addr_q, ram_w_addr_d;
    logic [31:0]       ram_w_line_q, ram_w_line_d;
    logic [31:0]       m0_rdata_q, m0_rdata_d;
    logic [31:0]       m1_rdata_q, m1_rdata_d;
    logic              m0_err_q, m0_err_d;
    logic              m1_err_q, m1_err_d;

    logic              pick;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              rdy_sel;
    logic              timeout_hit;
    logic              capture;
    logic [31:0]       cap_rdata;
    logic              cap_err;
    logic              busy;

    assign rdy_sel     = we_q ? ram_wrdy : ram_rrdy;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        pick      = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (m0_req && m1_req) begin
            pick = rr_m1_q;
        end else begin
            pick = m1_req;
        end
        if (pick) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end else begin
            sel_we    = m0_we;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_m1_d      = rr_m1_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        ram_r_addr_d = ram_r_addr_q;
        ram_w_addr_d = ram_w_addr_q;
        ram_w_line_d = ram_w_line_q;
        capture      = 1'b0;
        cap_rdata    = '0;
        cap_err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d   = pick;
                    rr_m1_d = ~pick;
                    we_d    = sel_we;
                    if (sel_we) begin
                        ram_w_addr_d = sel_addr;
                        ram_w_line_d = sel_wdata;
                    end else begin
                        ram_r_addr_d = sel_addr;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!rdy_sel) begin
                    cnt_d   = '0;
                    state_d = WAIT_HIGH;
                end else if (timeout_hit) begin
                    capture = 1'b1;
                    cap_err = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rdy_sel) begin
                    capture   = 1'b1;
                    cap_rdata = we_q ? 32'h0 : ram_r_line;
                    cap_err   = ram_exc;
                    state_d   = RESP;
                end else if (timeout_hit) begin
                    capture = 1'b1;
                    cap_err = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response registers change only for the owner, so the other master's rdata/err hold.
    always_comb begin
        m0_rdata_d = m0_rdata_q;
        m0_err_d   = m0_err_q;
        m1_rdata_d = m1_rdata_q;
        m1_err_d   = m1_err_q;
        if (capture) begin
            if (gnt_q) begin
                m1_rdata_d = cap_rdata;
                m1_err_d   = cap_err;
            end else begin
                m0_rdata_d = cap_rdata;
                m0_err_d   = cap_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            rr_m1_q      <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            ram_r_addr_q <= '0;
            ram_w_addr_q <= '0;
            ram_w_line_q <= '0;
            m0_rdata_q   <= '0;
            m0_err_q     <= 1'b0;
            m1_rdata_q   <= '0;
            m1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_m1_q      <= rr_m1_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            ram_r_addr_q <= ram_r_addr_d;
            ram_w_addr_q <= ram_w_addr_d;
            ram_w_line_q <= ram_w_line_d;
            m0_rdata_q   <= m0_rdata_d;
            m0_err_q     <= m0_err_d;
            m1_rdata_q   <= m1_rdata_d;
            m1_err_q     <= m1_err_d;
        end
    end

    // Strobes are decoded from state so only one can ever be high and both fall with the state.
    assign busy       = (state_q == ISSUE) || (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);
    assign ram_read   = busy && !we_q;
    assign ram_write  = busy && we_q;
    assign ram_r_addr = ram_r_addr_q;
    assign ram_w_addr = ram_w_addr_q;
    assign ram_w_line = ram_w_line_q;

    assign m0_ack   = (state_q == RESP) && !gnt_q;
    assign m1_ack   = (state_q == RESP) && gnt_q;
    assign m0_rdata = m0_rdata_q;
    assign m0_err   = m0_err_q;
    assign m1_rdata = m1_rdata_q;
    assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, randomized transactions against a cycle-count
// reference model, and a mid-transaction reset sequence.
module tb_ram_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] ram_r_addr, ram_w_addr, ram_w_line;
    logic        ram_read, ram_write;
    logic        ram_rrdy, ram_wrdy, ram_exc;
    logic [31:0] ram_r_line;

    int n_chk = 0;
    int n_fail = 0;
    int model_last;
    logic [31:0] exp_rd [2];
    logic        exp_er [2];

    ram_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_line(ram_w_line),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_rrdy(ram_rrdy), .ram_wrdy(ram_wrdy),
        .ram_r_line(ram_r_line), .ram_exc(ram_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        int          dlo, dhi;
        logic [31:0] line;
        logic        exc;
        logic        drop;
        int          win;
        logic [31:0] rd;
        logic        er;
        int          off;
    } vec_t;

    vec_t tbl [12];

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // One transaction: c = 0 is the IDLE cycle where the request is sampled, c = off is the ack cycle.
    task automatic run_txn(input vec_t v);
        logic        wwe, strobe_exp, lo;
        logic [31:0] wa, wd;
        wwe = (v.win == 1) ? v.w1 : v.w0;
        wa  = (v.win == 1) ? v.a1 : v.a0;
        wd  = (v.win == 1) ? v.d1 : v.d0;
        @(negedge clk);
        m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
        ram_r_line = v.line; ram_exc = v.exc; ram_rrdy = 1'b1; ram_wrdy = 1'b1;
        for (int c = 0; c <= v.off; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) begin
                if (v.win == 1) begin
                    if (v.drop) m1_req = 1'b0;
                    m1_addr = $urandom; m1_wdata = $urandom;
                end else begin
                    if (v.drop) m0_req = 1'b0;
                    m0_addr = $urandom; m0_wdata = $urandom;
                end
            end
            strobe_exp = (c >= 1) && (c < v.off);
            chk1("ram_read", ram_read, strobe_exp && !wwe);
            chk1("ram_write", ram_write, strobe_exp && wwe);
            if (strobe_exp && !wwe) chk32("ram_r_addr", ram_r_addr, wa);
            if (strobe_exp && wwe) begin
                chk32("ram_w_addr", ram_w_addr, wa);
                chk32("ram_w_line", ram_w_line, wd);
            end
            chk1("m0_ack", m0_ack, (c == v.off) && (v.win == 0));
            chk1("m1_ack", m1_ack, (c == v.off) && (v.win == 1));
            if (c == v.off) begin
                exp_rd[v.win] = v.rd;
                exp_er[v.win] = v.er;
                chk32("m0_rdata", m0_rdata, exp_rd[0]);
                chk1("m0_err", m0_err, exp_er[0]);
                chk32("m1_rdata", m1_rdata, exp_rd[1]);
                chk1("m1_err", m1_err, exp_er[1]);
                model_last = v.win;
            end
            // RAM responder: selected ready is low for dhi cycles starting dlo cycles after ISSUE
            lo = (c >= v.dlo + 1) && (c <= v.dlo + v.dhi);
            if (wwe) ram_wrdy = !lo;
            else     ram_rrdy = !lo;
        end
        ram_rrdy = 1'b1;
        ram_wrdy = 1'b1;
    endtask

    task automatic reset_model();
        model_last = 1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        exp_er[0] = 1'b0; exp_er[1] = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   ph_lo, ph_hi;
        logic tmo;

        //            r0 r1 w0 w1  a0        a1        d0     d1     dlo dhi line          exc  drop win rd            er  off
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h4,   32'h8,   32'h0, 32'hAB, 1, 1, 32'h55,       1'b0, 1'b0, 0, 32'h55,       1'b0, 4};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h4,   32'h8,   32'h0, 32'hAB, 1, 1, 32'h0,        1'b0, 1'b0, 1, 32'h0,        1'b0, 4};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0, 32'h0,  1, 1, 32'h11,       1'b0, 1'b0, 0, 32'h11,       1'b0, 4};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0, 32'h0,  1, 1, 32'h22,       1'b0, 1'b0, 1, 32'h22,       1'b0, 4};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0, 32'h0,  1, 1, 32'h33,       1'b0, 1'b0, 0, 32'h33,       1'b0, 4};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0, 32'h0,  1, 1, 32'h44,       1'b0, 1'b0, 1, 32'h44,       1'b0, 4};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10,  32'h0,   32'h0, 32'h0,  1, 1, 32'h20,       1'b0, 1'b1, 0, 32'h20,       1'b0, 4};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h30,  32'h0, 32'h0,  1, 1, 32'hDEADBEEF, 1'b1, 1'b1, 1, 32'hDEADBEEF, 1'b1, 4};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h34,  32'h0, 32'h77, 1, 1, 32'hFFFF,     1'b1, 1'b0, 1, 32'h0,        1'b1, 4};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h50,  32'h0,   32'h0, 32'h0,  100, 1, 32'h99,     1'b0, 1'b0, 0, 32'h0,        1'b1, 10};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h60,  32'h0, 32'h5A, 2, 100, 32'h1,      1'b0, 1'b0, 1, 32'h0,        1'b1, 12};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h70,  32'h0,   32'h0, 32'h0,  3, 2, 32'hCAFE,     1'b0, 1'b1, 0, 32'hCAFE,     1'b0, 7};

        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        ram_rrdy = 1'b1; ram_wrdy = 1'b1; ram_r_line = '0; ram_exc = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        chk1("rst ram_read", ram_read, 1'b0);
        chk1("rst ram_write", ram_write, 1'b0);
        chk32("rst ram_r_addr", ram_r_addr, 32'h0);
        chk32("rst ram_w_addr", ram_w_addr, 32'h0);
        chk32("rst ram_w_line", ram_w_line, 32'h0);
        chk1("rst m0_ack", m0_ack, 1'b0);
        chk1("rst m1_ack", m1_ack, 1'b0);
        chk32("rst m0_rdata", m0_rdata, 32'h0);
        chk32("rst m1_rdata", m1_rdata, 32'h0);
        chk1("rst m0_err", m0_err, 1'b0);
        chk1("rst m1_err", m1_err, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_txn(tbl[i]);

        // Randomized traffic; expectations come from the arbitration rule and per-phase delay caps.
        for (int i = 0; i < 60; i++) begin
            v.r0 = 1'($urandom_range(0, 1));
            v.r1 = 1'($urandom_range(0, 1));
            if (!v.r0 && !v.r1) v.r0 = 1'b1;
            v.w0 = 1'($urandom_range(0, 1)); v.w1 = 1'($urandom_range(0, 1));
            v.a0 = $urandom; v.a1 = $urandom; v.d0 = $urandom; v.d1 = $urandom;
            v.dlo = $urandom_range(1, 4);
            v.dhi = $urandom_range(1, 4);
            if ($urandom_range(0, 9) == 0) v.dlo = 40;
            if ($urandom_range(0, 9) == 0) v.dhi = 40;
            v.line = $urandom;
            v.exc = 1'($urandom_range(0, 1));
            v.drop = 1'($urandom_range(0, 1));
            if (v.r0 && v.r1) v.win = (model_last == 0) ? 1 : 0;
            else              v.win = v.r1 ? 1 : 0;
            ph_lo = (v.dlo > T) ? T : v.dlo;
            ph_hi = (v.dlo > T) ? 0 : ((v.dhi > T) ? T : v.dhi);
            tmo = (v.dlo > T) || (v.dhi > T);
            v.off = 1 + ph_lo + ph_hi + 1;
            v.er = tmo ? 1'b1 : v.exc;
            v.rd = (tmo || ((v.win == 1) ? v.w1 : v.w0)) ? 32'h0 : v.line;
            run_txn(v);
        end

        // Reset while in WAIT_HIGH: strobe must fall next cycle and no ack may follow.
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40; m1_req = 1'b0;
        ram_r_line = 32'h77; ram_exc = 1'b0;
        @(negedge clk);
        m0_req = 1'b0;
        @(negedge clk);
        ram_rrdy = 1'b0;
        @(negedge clk);
        chk1("midrst strobe before", ram_read, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ram_rrdy = 1'b1;
        reset_model();
        chk1("midrst ram_read", ram_read, 1'b0);
        chk1("midrst ram_write", ram_write, 1'b0);
        chk32("midrst ram_r_addr", ram_r_addr, 32'h0);
        chk32("midrst m0_rdata", m0_rdata, 32'h0);
        chk1("midrst m0_err", m0_err, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk1("midrst m0_ack", m0_ack, 1'b0);
            chk1("midrst m1_ack", m1_ack, 1'b0);
            if (c < 3) @(negedge clk);
        end
        v = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h80, 32'h0, 32'h0, 1, 1,
              32'h1234, 1'b0, 1'b1, 1, 32'h1234, 1'b0, 4};
        run_txn(v);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
